// File: rtl/wvb_hdr_bundle_2_builder.sv
// ---------------------------------------------------------------------------
// wvb_hdr_bundle_2_builder
//
// Waveform-buffer header builder for one mDOM digitizer channel. Captures the
// per-waveform metadata at trigger time and the stop address at end of
// waveform, then writes one packed 80-bit "bundle 2" header into the
// downstream header FIFO.
//
// Bundle layout (LSB first):
//   [48:0]  evt_ltc     [59:49] start_addr   [70:60] stop_addr
//   [72:71] trig_src    [73]    cnst_run     [78:74] pre_conf   [79] sync_rdy
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ltc             free-running local time counter (49 b)
//   wvb_wr_addr     current waveform buffer write address
//   trig            single-cycle start-of-waveform pulse
//   trig_done       single-cycle last-sample-written pulse
//   trig_src_in, cnst_run_in, pre_conf_in, sync_rdy_in
//                   per-waveform metadata, sampled on an accepted trig
//   hdr_full        header FIFO full
//   hdr_data        packed header bundle
//   hdr_wr_en       header FIFO write strobe (combinational with hdr_full)
//   busy            high while a waveform is open or its header is pending
//   drop_cnt        number of triggers that arrived while busy
//
// Build option:
//   WVB_HDR_DROP_CNT_EN  when defined, drop_cnt is a saturating 16-bit
//                        counter of dropped triggers; otherwise it is tied
//                        to zero and no counter is built.
// ---------------------------------------------------------------------------
module wvb_hdr_bundle_2_builder #(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [48:0]       ltc,
  input  logic [ADDR_W-1:0] wvb_wr_addr,
  input  logic              trig,
  input  logic              trig_done,
  input  logic [1:0]        trig_src_in,
  input  logic              cnst_run_in,
  input  logic [4:0]        pre_conf_in,
  input  logic              sync_rdy_in,
  input  logic              hdr_full,
  output logic [79:0]       hdr_data,
  output logic              hdr_wr_en,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  // Span counter only has to reach MAX_LEN-1 before the forced stop.
  localparam int SPAN_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
  localparam logic [SPAN_W-1:0] SPAN_LAST = SPAN_W'(MAX_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    WRITE  = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [48:0]       evt_ltc_reg;
  logic [ADDR_W-1:0] start_addr_reg;
  logic [ADDR_W-1:0] stop_addr_reg;
  logic [1:0]        trig_src_reg;
  logic              cnst_run_reg;
  logic [4:0]        pre_conf_reg;
  logic              sync_rdy_reg;
  logic [SPAN_W-1:0] span_reg;

  logic accept;
  logic stop_hit;

  assign accept   = (state_reg == IDLE) && trig;
  // trig_done takes priority over a coincident trig: the trig is simply
  // not accepted because we are not in IDLE.
  assign stop_hit = (state_reg == ACTIVE) && (trig_done || (span_reg == SPAN_LAST));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (trig)      state_next = ACTIVE;
      ACTIVE:  if (stop_hit)  state_next = WRITE;
      WRITE:   if (!hdr_full) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = (state_reg != IDLE);
    hdr_wr_en = (state_reg == WRITE) && !hdr_full;
  end

  // -------------------------------------------------------------------------
  // Header field capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_ltc_reg    <= '0;
      start_addr_reg <= '0;
      stop_addr_reg  <= '0;
      trig_src_reg   <= '0;
      cnst_run_reg   <= 1'b0;
      pre_conf_reg   <= '0;
      sync_rdy_reg   <= 1'b0;
      span_reg       <= '0;
    end else begin
      if (accept) begin
        evt_ltc_reg    <= ltc;
        // Pretrigger samples precede the trigger address; the buffer is a
        // ring, so the subtraction wraps modulo the address space.
        start_addr_reg <= wvb_wr_addr - ADDR_W'(pre_conf_in);
        trig_src_reg   <= trig_src_in;
        cnst_run_reg   <= cnst_run_in;
        pre_conf_reg   <= pre_conf_in;
        sync_rdy_reg   <= sync_rdy_in;
        span_reg       <= '0;
      end else if (state_reg == ACTIVE) begin
        span_reg <= span_reg + SPAN_W'(1);
      end

      if (stop_hit) begin
        stop_addr_reg <= wvb_wr_addr;
      end
    end
  end

  assign hdr_data = {sync_rdy_reg, pre_conf_reg, cnst_run_reg, trig_src_reg,
                     stop_addr_reg, start_addr_reg, evt_ltc_reg};

  // -------------------------------------------------------------------------
  // Dropped-trigger counter
  // -------------------------------------------------------------------------
`ifdef WVB_HDR_DROP_CNT_EN
  logic        drop_evt;
  logic [15:0] drop_cnt_reg;

  assign drop_evt = trig && (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= 16'h0000;
    end else if (drop_evt && (drop_cnt_reg != 16'hFFFF)) begin
      drop_cnt_reg <= drop_cnt_reg + 16'h0001;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: doc/wvb_hdr_bundle_2_builder.md
Name: wvb_hdr_bundle_2_builder

Overview:
- Waveform-buffer header builder for the mDOM digitizer channel.
- Captures per-waveform metadata at trigger and end of waveform, and packs it into the 80-bit mDOM wvb header bundle 2 format.
- Writes one bundle per waveform into the downstream header FIFO.
- Sits between the channel trigger/write-address logic and the header FIFO; the readout side unpacks the same bundle.

Parameters:
- ADDR_W, 11, waveform buffer address width; fixed by the bundle format, not to be changed.
- MAX_LEN, 2047, maximum waveform span in samples before a forced stop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ltc  in  49  free-running local time counter
- wvb_wr_addr  in  11  current waveform buffer write address
- trig  in  1  single-cycle trigger pulse, start of waveform
- trig_done  in  1  single-cycle pulse, last sample written
- trig_src_in  in  2  trigger source, sampled on trig
- cnst_run_in  in  1  constant-run flag, sampled on trig
- pre_conf_in  in  5  pretrigger sample count, sampled on trig
- sync_rdy_in  in  1  time-sync-ready flag, sampled on trig
- hdr_full  in  1  header FIFO full
- hdr_data  out  80  packed header bundle
- hdr_wr_en  out  1  header FIFO write strobe
- busy  out  1  high in any state except IDLE
- drop_cnt  out  16  dropped-trigger count (see Optional Feature)

Behaviour:
- Bundle bit map, LSB first:
  - evt_ltc [48:0]
  - start_addr [59:49]
  - stop_addr [70:60]
  - trig_src [72:71]
  - cnst_run [73]
  - pre_conf [78:74]
  - sync_rdy [79]
- FSM states: IDLE, ACTIVE, WRITE.
- IDLE, trig=1:
  - Register evt_ltc=ltc, trig_src, cnst_run, pre_conf, sync_rdy.
  - Register start_addr=(wvb_wr_addr - pre_conf_in) mod 2048; 11-bit wrap, no borrow.
  - Clear span counter; go to ACTIVE.
- ACTIVE:
  - Span counter increments each cycle.
  - On trig_done=1, or span counter reaching MAX_LEN-1: register stop_addr=wvb_wr_addr; go to WRITE.
  - A trig arriving in ACTIVE is ignored and counted as a drop.
  - trig and trig_done in the same cycle: trig_done wins and trig is dropped.
- WRITE:
  - hdr_wr_en = (state==WRITE) && !hdr_full; combinational, asserted for exactly one cycle per header.
  - hdr_data holds the registered fields, stable for the whole time in WRITE.
  - hdr_full=1: remain in WRITE indefinitely, no write.
  - On the cycle hdr_wr_en=1: return to IDLE.
  - A trig arriving in WRITE is dropped.
- Latency: trig_done sampled at edge k → first possible hdr_wr_en in cycle k+1.
- Minimum trig-to-trig spacing: trig, trig_done, write, then the next trig is accepted in IDLE.
- busy is high in ACTIVE and WRITE.
- Reset (at any time, including mid-ACTIVE or mid-WRITE):
  - state goes to IDLE; all header fields and hdr_data go to 0; hdr_wr_en=0; busy=0; drop_cnt=0.
  - A pending header is discarded, not written.
- Outputs are reset-only; no asynchronous paths except the combinational hdr_wr_en from hdr_full.

Optional Feature:
- Macro WVB_HDR_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter that increments once per dropped trig; it saturates at 16'hFFFF and clears only on rst.
- Undefined: no counter logic is built and drop_cnt is tied to 16'h0000; all other behaviour is identical.

Test Plan:
- Basic build:
  - Stimulus: ltc=49'h1_2345_6789_ABCD, wvb_wr_addr=100, pre_conf_in=5, trig_src_in=2'b10, cnst_run_in=0, sync_rdy_in=1, trig; trig_done 20 cycles later with wvb_wr_addr=120; hdr_full=0.
  - Response: one hdr_wr_en cycle after trig_done, with start_addr=95, stop_addr=120, bit79=1, bits[72:71]=2'b10, bits[48:0] equal to the captured ltc.
- Start-address wrap:
  - Stimulus: wvb_wr_addr=3, pre_conf_in=10.
  - Response: start_addr=2041.
- Backpressure:
  - Stimulus: hdr_full held high for 50 cycles after trig_done.
  - Response: hdr_wr_en=0 throughout, hdr_data stable, busy=1; when hdr_full falls, exactly one write, then busy=0.
- Drops, with WVB_HDR_DROP_CNT_EN defined:
  - Stimulus: 3 trigs during ACTIVE, 1 trig during WRITE, 1 trig coincident with trig_done.
  - Response: drop_cnt=5, exactly one header written.
  - With the macro undefined, drop_cnt=0 for the same stimulus.
- Forced stop:
  - Stimulus: MAX_LEN=16, trig with no trig_done.
  - Response: WRITE entered 16 cycles after trig; stop_addr equals wvb_wr_addr at that edge.
- Reset mid-WRITE:
  - Stimulus: rst asserted while in WRITE with hdr_full=1.
  - Response: next cycle hdr_data=0, busy=0, drop_cnt=0; no hdr_wr_en after hdr_full falls.
